// File: rtl/pad_line_mux_sync_if.sv
// Pad-line bus bundle: per-macro o/oe buses in, selected o/oe out, and the
// pad input path broadcast back to the macros.
interface pad_line_mux_sync_if #(
    parameter int N_MACROS = 2,
    parameter int WIDTH    = 10
) ();
    logic [N_MACROS*WIDTH-1:0] north_o_bus;
    logic [N_MACROS*WIDTH-1:0] north_oe_bus;
    logic [WIDTH-1:0]          north_o_selected;
    logic [WIDTH-1:0]          north_oe_selected;
    logic [WIDTH-1:0]          north_i;
    logic [WIDTH-1:0]          north_i_sync;

    // macro array / pad ring side
    modport master (
        output north_o_bus, north_oe_bus, north_i,
        input  north_o_selected, north_oe_selected, north_i_sync
    );

    // selector side
    modport slave (
        input  north_o_bus, north_oe_bus, north_i,
        output north_o_selected, north_oe_selected, north_i_sync
    );
endinterface

// File: rtl/pad_line_mux_sync.sv
// Registered pad-line selector with break-before-make switching.
// A configuration change tri-states the line (oe low) for GUARD_CYCLES+1
// cycles before the new macro takes over, so two macros never drive the pads.
// Optional macro PAD_IN_SYNC_EN: adds a 2-flop synchroniser on the pad inputs;
// otherwise the pad inputs pass straight through.
//
//   state  | meaning
//   ACTIVE | line owned by macro sel_idx, o/oe registered from it
//   DRAIN  | oe forced low, guard counting towards latched target
module pad_line_mux_sync #(
    parameter int N_MACROS     = 2,
    parameter int WIDTH        = 10,
    parameter int CFG_W        = 4,
    parameter int GUARD_CYCLES = 2,
    localparam int SEL_W       = $clog2(N_MACROS),
    localparam int CNT_W       = $clog2(GUARD_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CFG_W-1:0] configuration,
    pad_line_mux_sync_if.slave bus,
    output logic [SEL_W-1:0] sel_idx,
    output logic             switching
);

    typedef enum logic {
        ACTIVE = 1'b0,
        DRAIN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [SEL_W-1:0] r_sel_idx;
    logic [SEL_W-1:0] r_tgt;
    logic [WIDTH-1:0] r_o_sel;
    logic [WIDTH-1:0] r_oe_sel;

    state_t           w_nxt_state;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic [SEL_W-1:0] w_nxt_sel_idx;
    logic [SEL_W-1:0] w_nxt_tgt;
    logic [WIDTH-1:0] w_nxt_o_sel;
    logic [WIDTH-1:0] w_nxt_oe_sel;
    logic [SEL_W-1:0] w_tgt;
    logic [31:0]      w_cfg_u;
    logic [WIDTH-1:0] w_o_cur;
    logic [WIDTH-1:0] w_oe_cur;

    // Decode the configuration word into a target macro; out-of-range words map to 0
    always_comb begin
        w_cfg_u = 32'(configuration);
        if (w_cfg_u < 32'(2 * N_MACROS))
            w_tgt = SEL_W'(w_cfg_u % 32'(N_MACROS));
        else
            w_tgt = '0;
    end

    // Pick the current owner's slices out of the packed buses
    always_comb begin
        w_o_cur  = bus.north_o_bus[int'(r_sel_idx)*WIDTH +: WIDTH];
        w_oe_cur = bus.north_oe_bus[int'(r_sel_idx)*WIDTH +: WIDTH];
    end

    // Next-state and next-output logic for the ownership FSM
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_cnt     = r_cnt;
        w_nxt_sel_idx = r_sel_idx;
        w_nxt_tgt     = r_tgt;
        w_nxt_o_sel   = r_o_sel;
        w_nxt_oe_sel  = r_oe_sel;
        case (r_state)
            ACTIVE: begin
                if (w_tgt != r_sel_idx) begin
                    w_nxt_state  = DRAIN;
                    w_nxt_tgt    = w_tgt;
                    w_nxt_cnt    = '0;
                    w_nxt_oe_sel = '0;
                end else begin
                    w_nxt_o_sel  = w_o_cur;
                    w_nxt_oe_sel = w_oe_cur;
                end
            end
            DRAIN: begin
                w_nxt_oe_sel = '0;
                // a new request restarts the guard; returning to the current
                // owner still waits out the full guard
                if (w_tgt != r_tgt) begin
                    w_nxt_tgt = w_tgt;
                    w_nxt_cnt = '0;
                end else if (r_cnt == CNT_W'(GUARD_CYCLES - 1)) begin
                    w_nxt_sel_idx = r_tgt;
                    w_nxt_state   = ACTIVE;
                end else begin
                    w_nxt_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: w_nxt_state = DRAIN;
        endcase
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= DRAIN;
            r_cnt     <= '0;
            r_sel_idx <= '0;
            r_tgt     <= '0;
            r_o_sel   <= '0;
            r_oe_sel  <= '0;
        end else begin
            r_state   <= w_nxt_state;
            r_cnt     <= w_nxt_cnt;
            r_sel_idx <= w_nxt_sel_idx;
            r_tgt     <= w_nxt_tgt;
            r_o_sel   <= w_nxt_o_sel;
            r_oe_sel  <= w_nxt_oe_sel;
        end
    end

    assign bus.north_o_selected  = r_o_sel;
    assign bus.north_oe_selected = r_oe_sel;
    assign sel_idx               = r_sel_idx;
    assign switching             = (r_state != ACTIVE);

`ifdef PAD_IN_SYNC_EN
    logic [WIDTH-1:0] r_i_meta;
    logic [WIDTH-1:0] r_i_sync;

    // Two-flop synchroniser on the asynchronous pad inputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_i_meta <= '0;
            r_i_sync <= '0;
        end else begin
            r_i_meta <= bus.north_i;
            r_i_sync <= r_i_meta;
        end
    end

    assign bus.north_i_sync = r_i_sync;
`else
    assign bus.north_i_sync = bus.north_i;
`endif

endmodule

// File: tb/tb_pad_line_mux_sync.sv
// Directed bench for pad_line_mux_sync: a 2-macro/10-bit instance and a
// 3-macro/4-bit instance, expectations queued before each edge and checked after it.
module tb_pad_line_mux_sync;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cfg_a;
    logic [3:0] cfg_b;
    logic [0:0] sel_a;
    logic [1:0] sel_b;
    logic       sw_a;
    logic       sw_b;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        string      tag;
        bit         which;
        logic [9:0] o;
        logic [9:0] oe;
        logic [1:0] sel;
        logic       sw;
    } exp_t;

    exp_t sb_q[$];

    pad_line_mux_sync_if #(.N_MACROS(2), .WIDTH(10)) bus_a ();
    pad_line_mux_sync_if #(.N_MACROS(3), .WIDTH(4))  bus_b ();

    pad_line_mux_sync #(.N_MACROS(2), .WIDTH(10), .CFG_W(4), .GUARD_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .configuration(cfg_a), .bus(bus_a),
        .sel_idx(sel_a), .switching(sw_a)
    );

    pad_line_mux_sync #(.N_MACROS(3), .WIDTH(4), .CFG_W(4), .GUARD_CYCLES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .configuration(cfg_b), .bus(bus_b),
        .sel_idx(sel_b), .switching(sw_b)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // queue the expected post-edge outputs, advance one edge, then score
    task automatic step(input bit which, input logic [9:0] o, input logic [9:0] oe,
                        input logic [1:0] sel, input logic sw, input string tag);
        exp_t e;
        sb_q.push_back('{tag, which, o, oe, sel, sw});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        if (e.which == 1'b0) begin
            cmp({e.tag, ".o"},   32'(bus_a.north_o_selected),  32'(e.o));
            cmp({e.tag, ".oe"},  32'(bus_a.north_oe_selected), 32'(e.oe));
            cmp({e.tag, ".sel"}, 32'(sel_a),                   32'(e.sel));
            cmp({e.tag, ".sw"},  32'(sw_a),                    32'(e.sw));
        end else begin
            cmp({e.tag, ".o"},   32'(bus_b.north_o_selected),  32'(e.o));
            cmp({e.tag, ".oe"},  32'(bus_b.north_oe_selected), 32'(e.oe));
            cmp({e.tag, ".sel"}, 32'(sel_b),                   32'(e.sel));
            cmp({e.tag, ".sw"},  32'(sw_b),                    32'(e.sw));
        end
    endtask

    localparam logic [9:0] O0  = 10'h0F0;
    localparam logic [9:0] O1  = 10'h2A5;
    localparam logic [9:0] OE0 = 10'h3FF;
    localparam logic [9:0] OE1 = 10'h155;

    initial begin
        rst_n = 1'b0;
        cfg_a = 4'd0;
        cfg_b = 4'd0;
        bus_a.north_o_bus  = {O1, O0};
        bus_a.north_oe_bus = {OE1, OE0};
        bus_a.north_i      = 10'h000;
        bus_b.north_o_bus  = {4'hC, 4'hB, 4'hA};
        bus_b.north_oe_bus = {4'h7, 4'h3, 4'h1};
        bus_b.north_i      = 4'h0;

        // reset and post-reset blanking
        step(0, 10'h0, 10'h0, 2'd0, 1'b1, "rst0");
        step(0, 10'h0, 10'h0, 2'd0, 1'b1, "rst1");
`ifdef PAD_IN_SYNC_EN
        cmp("isync_rst", 32'(bus_a.north_i_sync), 32'h0);
`endif
        rst_n = 1'b1;
        step(0, 10'h0, 10'h0, 2'd0, 1'b1, "blank_a");
        step(0, 10'h0, 10'h0, 2'd0, 1'b0, "blank_b");
        step(0, O0,    OE0,   2'd0, 1'b0, "track0");

        // switch 0 -> 1
        cfg_a = 4'd3;
        step(0, O0, 10'h0, 2'd0, 1'b1, "sw01_d0");
        step(0, O0, 10'h0, 2'd0, 1'b1, "sw01_d1");
        step(0, O0, 10'h0, 2'd1, 1'b0, "sw01_d2");
        step(0, O1, OE1,   2'd1, 1'b0, "sw01_new");
        step(0, O1, OE1,   2'd1, 1'b0, "sw01_hold");

        // out-of-range word decodes to macro 0
        cfg_a = 4'd9;
        step(0, O1, 10'h0, 2'd1, 1'b1, "cfg9_d0");
        step(0, O1, 10'h0, 2'd1, 1'b1, "cfg9_d1");
        step(0, O1, 10'h0, 2'd0, 1'b0, "cfg9_d2");
        step(0, O0, OE0,   2'd0, 1'b0, "cfg9_new");

        // request changes mid-guard: guard restarts, ends back on 0
        cfg_a = 4'd1;
        step(0, O0, 10'h0, 2'd0, 1'b1, "rst_g0");
        cfg_a = 4'd2;
        step(0, O0, 10'h0, 2'd0, 1'b1, "rst_g1");
        step(0, O0, 10'h0, 2'd0, 1'b1, "rst_g2");
        step(0, O0, 10'h0, 2'd0, 1'b0, "rst_g3");
        step(0, O0, OE0,   2'd0, 1'b0, "rst_g_end");

        // reset in the middle of a drain
        cfg_a = 4'd1;
        step(0, O0, 10'h0, 2'd0, 1'b1, "mid_d0");
        step(0, O0, 10'h0, 2'd0, 1'b1, "mid_d1");
        rst_n = 1'b0;
        cfg_a = 4'd0;
        step(0, 10'h0, 10'h0, 2'd0, 1'b1, "mid_rst");
        rst_n = 1'b1;
        step(0, 10'h0, 10'h0, 2'd0, 1'b1, "mid_blank_a");
        step(0, 10'h0, 10'h0, 2'd0, 1'b0, "mid_blank_b");
        step(0, O0,    OE0,   2'd0, 1'b0, "mid_track");

        // three-macro instance: cfg 5 -> macro 2, cfg 6 -> macro 0
        cfg_b = 4'd5;
        step(1, 10'hA, 10'h0, 2'd0, 1'b1, "n3_d0");
        step(1, 10'hA, 10'h0, 2'd0, 1'b1, "n3_d1");
        step(1, 10'hA, 10'h0, 2'd2, 1'b0, "n3_d2");
        step(1, 10'hC, 10'h7, 2'd2, 1'b0, "n3_sel2");
        cfg_b = 4'd6;
        step(1, 10'hC, 10'h0, 2'd2, 1'b1, "n3_b0");
        step(1, 10'hC, 10'h0, 2'd2, 1'b1, "n3_b1");
        step(1, 10'hC, 10'h0, 2'd0, 1'b0, "n3_b2");
        step(1, 10'hA, 10'h1, 2'd0, 1'b0, "n3_sel0");

        // pad input path
        bus_a.north_i = 10'h155;
`ifdef PAD_IN_SYNC_EN
        @(posedge clk); #1;
        cmp("isync_1edge", 32'(bus_a.north_i_sync), 32'h0);
        @(posedge clk); #1;
        cmp("isync_2edge", 32'(bus_a.north_i_sync), 32'h155);
`else
        #1;
        cmp("isync_155", 32'(bus_a.north_i_sync), 32'h155);
        bus_a.north_i = 10'h2AA;
        #1;
        cmp("isync_2AA", 32'(bus_a.north_i_sync), 32'h2AA);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
